// File: rtl/divider_pkg.sv
// Shared definitions for the bit-serial restoring divider.
//   DEF_WIDTH : default divisor/remainder width (dividend/quotient are twice this)
//   DEF_CNT_W : iteration counter width for the default width
//   state_e   : divider control states
package divider_pkg;

  localparam int unsigned DEF_WIDTH = 192;
  localparam int unsigned DEF_CNT_W = $clog2(2 * DEF_WIDTH + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
//   rem      : current partial remainder (always < d)
//   nbit     : next dividend bit, MSB first
//   d        : divisor
//   rem_next : updated partial remainder
//   qbit     : quotient bit produced by this iteration
module div_step #(
  parameter int unsigned WIDTH = 192
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             nbit,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rem_next,
  output logic             qbit
);

  // t is one bit wider than the divisor so the compare cannot overflow.
  logic [WIDTH:0] t;

  assign t    = {rem, nbit};
  assign qbit = (t >= {1'b0, d});
  // When qbit=1 the true difference is < d, so modulo-2^WIDTH subtraction is exact.
  assign rem_next = qbit ? (t[WIDTH-1:0] - d) : t[WIDTH-1:0];

endmodule

// File: rtl/restoring_divider.sv
// Bit-serial restoring integer divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock.
//   clk   : clock, rising edge
//   rst   : synchronous active-low reset
//   start : one-cycle request, sampled only while busy=0
//   n, d  : dividend / divisor, captured on the accepted start edge
//   busy  : division in progress
//   done  : one-cycle pulse, q/r/dz valid
//   q, r  : quotient / remainder, held until overwritten by the next result
//   dz    : divide-by-zero flag for the last operation
module restoring_divider
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = $clog2(2 * WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] n,
  input  logic [WIDTH-1:0]   d,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] q,
  output logic [WIDTH-1:0]   r,
  output logic               dz
);

  localparam int unsigned NW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NW - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Dividend shifts out of the MSB while quotient bits fill in from the LSB.
  logic [NW-1:0]    sreg_q, sreg_d;
  // Remainder stays below d after each step, so WIDTH bits hold it; the widened
  // intermediate lives inside div_step.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dreg_q, dreg_d;
  logic [NW-1:0]    q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  // Divide-by-zero request seen; result is published on the following edge.
  logic             dzp_q, dzp_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem_q),
    .nbit    (sreg_q[NW-1]),
    .d       (dreg_q),
    .rem_next(step_rem),
    .qbit    (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    rem_d   = rem_q;
    dreg_d  = dreg_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    dzp_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dzp_q) begin
          done_d = 1'b1;
          dz_d   = 1'b1;
          q_d    = '1;
          r_d    = sreg_q[WIDTH-1:0];
        end else if (start) begin
          sreg_d = n;
          if (d != '0) begin
            dreg_d  = d;
            rem_d   = '0;
            cnt_d   = '0;
            dz_d    = 1'b0;
            state_d = RUN;
          end else begin
            dzp_d = 1'b1;
          end
        end
      end
      RUN: begin
        rem_d  = step_rem;
        sreg_d = {sreg_q[NW-2:0], step_qbit};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          q_d     = {sreg_q[NW-2:0], step_qbit};
          r_d     = step_rem;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      rem_q   <= '0;
      dreg_q  <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      dzp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      rem_q   <= rem_d;
      dreg_q  <= dreg_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      dzp_q   <= dzp_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and randomized self-checking bench for restoring_divider (default width).
module tb_restoring_divider;

  localparam int W  = 192;
  localparam int NW = 2 * W;
  localparam int PW = NW + W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [NW-1:0] n = '0;
  logic [W-1:0]  d = '0;
  logic          busy, done, dz;
  logic [NW-1:0] q;
  logic [W-1:0]  r;

  int checks = 0;
  int errors = 0;

  restoring_divider dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .n    (n),
    .d    (d),
    .busy (busy),
    .done (done),
    .q    (q),
    .r    (r),
    .dz   (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench #1 after the edge that samples start.
  task automatic issue(input logic [NW-1:0] nv, input logic [W-1:0] dv);
    @(negedge clk);
    start = 1'b1;
    n     = nv;
    d     = dv;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen, and cycles with busy high (including now).
  task automatic wait_done(output int cyc, output int bc);
    cyc = 0;
    bc  = busy ? 1 : 0;
    while (done !== 1'b1 && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy) bc++;
    end
  endtask

  task automatic run(input logic [NW-1:0] nv, input logic [W-1:0] dv, output int cyc,
                     output int bc);
    issue(nv, dv);
    wait_done(cyc, bc);
  endtask

  initial begin
    int cyc, bc, seen;
    logic [NW-1:0] ones, nexp, qa, nv;
    logic [W-1:0]  dc, dv;
    logic [PW-1:0] prod;

    ones = '1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", NW'(busy), 0);
    check("rst_done", NW'(done), 0);
    check("rst_q", q, 0);
    check("rst_r", NW'(r), 0);
    check("rst_dz", NW'(dz), 0);
    @(negedge clk);
    rst = 1'b1;

    run(6, 3, cyc, bc);
    check("6_3_lat", NW'(cyc), 384);
    check("6_3_busy_cycles", NW'(bc), 384);
    check("6_3_q", q, 2);
    check("6_3_r", NW'(r), 0);
    check("6_3_dz", NW'(dz), 0);
    @(posedge clk);
    #1;
    check("6_3_done_pulse", NW'(done), 0);
    check("6_3_q_hold", q, 2);

    run(5, 9, cyc, bc);
    check("5_9_q", q, 0);
    check("5_9_r", NW'(r), 5);

    run(ones, 1, cyc, bc);
    check("max_1_q", q, ones);
    check("max_1_r", NW'(r), 0);

    dv = '1;
    run(ones, dv, cyc, bc);
    check("max_maxd_q", q, (NW'(1) << 192) + NW'(1));
    check("max_maxd_r", NW'(r), 0);

    qa   = (NW'(1) << 191) + NW'(3);
    dc   = '1;
    dc   = dc - W'(4);
    nexp = qa * NW'(dc) + NW'(7);
    run(nexp, dc, cyc, bc);
    check("big_q", q, qa);
    check("big_r", NW'(r), 7);

    run(NW'(16'h1234), 0, cyc, bc);
    check("dz_lat", NW'(cyc), 1);
    check("dz_flag", NW'(dz), 1);
    check("dz_q", q, ones);
    check("dz_r", NW'(r), NW'(16'h1234));
    check("dz_busy", NW'(busy), 0);
    run(100, 7, cyc, bc);
    check("after_dz_flag", NW'(dz), 0);
    check("after_dz_q", q, 14);
    check("after_dz_r", NW'(r), 2);

    // start pulsed mid-run with other operands must be ignored
    issue(1000, 10);
    repeat (50) begin
      @(posedge clk);
      #1;
    end
    issue(77, 5);
    wait_done(cyc, bc);
    check("ign_lat", NW'(cyc + 51), 384);
    check("ign_q", q, 100);
    check("ign_r", NW'(r), 0);

    // reset at iteration 100 aborts without a done pulse
    issue(12345, 11);
    repeat (100) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", NW'(busy), 0);
    check("abort_done", NW'(done), 0);
    check("abort_q", q, 0);
    check("abort_r", NW'(r), 0);
    @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    repeat (400) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("abort_no_done", NW'(seen), 0);
    run(12345, 11, cyc, bc);
    check("post_abort_lat", NW'(cyc), 384);
    check("post_abort_q", q, 1122);
    check("post_abort_r", NW'(r), 3);

    // back-to-back: start in the done cycle
    run(6, 3, cyc, bc);
    issue(100, 7);
    check("b2b_done_low", NW'(done), 0);
    check("b2b_busy", NW'(busy), 1);
    wait_done(cyc, bc);
    check("b2b_lat", NW'(cyc), 384);
    check("b2b_q", q, 14);
    check("b2b_r", NW'(r), 2);

    for (int k = 0; k < 20; k++) begin
      nv = '0;
      for (int i = 0; i < 12; i++) nv = {nv[NW-33:0], $urandom()};
      dv = '0;
      for (int i = 0; i < 6; i++) dv = {dv[W-33:0], $urandom()};
      dv = dv >> $urandom_range(0, 190);
      if (dv == '0) dv = 1;
      run(nv, dv, cyc, bc);
      prod = PW'(q) * PW'(dv) + PW'(r);
      check("rnd_lat", NW'(cyc), 384);
      check("rnd_dz", NW'(dz), 0);
      check("rnd_qdr_lo", prod[NW-1:0], nv);
      check("rnd_qdr_hi", NW'(prod[PW-1:NW]), 0);
      check("rnd_r_lt_d", NW'(r < dv), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
